// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   MUL_W    : operand width
//   MUL_ITER : number of multiplier bits consumed by CALC
//   CNT_W    : width of the CALC iteration counter
//   state_t  : controller states; encodings come from the localparams below
//   magnitude: absolute value of a two's-complement operand
package shift_add_mul_pkg;

  localparam int unsigned MUL_W    = 32;
  localparam int unsigned MUL_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(MUL_ITER);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CALC   = 3'd1;
  localparam logic [2:0] NEG_LO = 3'd2;
  localparam logic [2:0] NEG_HI = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_CALC   = CALC,
    ST_NEG_LO = NEG_LO,
    ST_NEG_HI = NEG_HI,
    ST_DONE   = DONE
  } state_t;

  function automatic logic [MUL_W-1:0] magnitude(input logic [MUL_W-1:0] x);
    return x[MUL_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/shift_add_mul_if.sv
// Request/result bundle of the shift-and-add multiplier.
//   i_valid/o_ready       : operation handshake (requester -> multiplier)
//   i_op_a/i_op_b         : multiplicand / multiplier
//   i_signed              : operands are two's complement
//   o_valid/i_ack         : result handshake (multiplier -> consumer)
//   o_prod                : 64-bit product
//   o_busy                : multiplier is not idle
// master = requester/consumer side, slave = multiplier side.
interface shift_add_mul_if;
  import shift_add_mul_pkg::*;

  logic               i_valid;
  logic               o_ready;
  logic [MUL_W-1:0]   i_op_a;
  logic [MUL_W-1:0]   i_op_b;
  logic               i_signed;
  logic               o_valid;
  logic               i_ack;
  logic [2*MUL_W-1:0] o_prod;
  logic               o_busy;

  modport master (
    output i_valid, i_op_a, i_op_b, i_signed, i_ack,
    input  o_ready, o_valid, o_prod, o_busy
  );

  modport slave (
    input  i_valid, i_op_a, i_op_b, i_signed, i_ack,
    output o_ready, o_valid, o_prod, o_busy
  );

endinterface

// File: rtl/shift_add_mul_fa.sv
// FA_32bit: 32-bit ripple-carry adder, the multiplier's only arithmetic unit.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low 32 bits)
//   cout : carry out of bit 31
module FA_32bit
  import shift_add_mul_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  input  logic             cin,
  output logic [MUL_W-1:0] sum,
  output logic             cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < MUL_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential 32x32 -> 64 shift-and-add multiplier.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus (slave)    : i_valid/o_ready request, i_op_a/i_op_b/i_signed operands,
//                    o_valid/i_ack result handshake, o_prod product, o_busy
// Parameter EARLY_EXIT: 1 = stop CALC once the remaining multiplier bits are 0.
// Macro SHIFT_ADD_MUL_SIGNED_EN: enables signed operation (magnitudes at
// accept, product negated in NEG_LO/NEG_HI). Without it i_signed is ignored.
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  shift_add_mul_if.slave bus
);

  state_t              state;
  logic [MUL_W-1:0]    mcand;
  logic [MUL_W-1:0]    mplier;
  logic [MUL_W-1:0]    acc_hi;
  logic [MUL_W-1:0]    acc_lo;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic                carry;

  logic [MUL_W-1:0]    add_a;
  logic [MUL_W-1:0]    add_b;
  logic                add_cin;
  logic [MUL_W-1:0]    add_sum;
  logic                add_cout;

  logic                take_signed;
  logic                calc_end;
  logic [CNT_W-1:0]    rem;
  logic [2*MUL_W-1:0]  shifted;
  logic [2*MUL_W-1:0]  calc_next;

`ifdef SHIFT_ADD_MUL_SIGNED_EN
  assign take_signed = bus.i_signed;
`else
  logic unused_signed;
  assign unused_signed = bus.i_signed;
  assign take_signed   = 1'b0;
`endif

  FA_32bit u_fa (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Adder operands by state: partial-product add in CALC, two-step
  // two's-complement negation of the 64-bit product in NEG_LO/NEG_HI.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      ST_CALC: begin
        add_a = acc_hi;
        add_b = mplier[0] ? mcand : '0;
      end
      ST_NEG_LO: begin
        add_a   = ~acc_lo;
        add_cin = 1'b1;
      end
      ST_NEG_HI: begin
        add_a   = ~acc_hi;
        add_cin = carry;
      end
      default: ;
    endcase
  end

  // On an early exit the skipped iterations would only add zero and shift,
  // so they collapse into a single right shift by the remaining count.
  assign calc_end  = (cnt == CNT_W'(MUL_ITER - 1)) ||
                     ((EARLY_EXIT != 0) && (mplier[MUL_W-1:1] == '0));
  assign rem       = CNT_W'(MUL_ITER - 1) - cnt;
  assign shifted   = {add_cout, add_sum, acc_lo[MUL_W-1:1]};
  assign calc_next = calc_end ? (shifted >> rem) : shifted;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      carry  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_valid) begin
            mcand  <= take_signed ? magnitude(bus.i_op_a) : bus.i_op_a;
            mplier <= take_signed ? magnitude(bus.i_op_b) : bus.i_op_b;
            neg    <= take_signed & (bus.i_op_a[MUL_W-1] ^ bus.i_op_b[MUL_W-1]);
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          {acc_hi, acc_lo} <= calc_next;
          mplier           <= mplier >> 1;
          cnt              <= cnt + CNT_W'(1);
          if (calc_end) begin
            state <= neg ? ST_NEG_LO : ST_DONE;
          end
        end
        ST_NEG_LO: begin
          acc_lo <= add_sum;
          carry  <= add_cout;
          state  <= ST_NEG_HI;
        end
        ST_NEG_HI: begin
          acc_hi <= add_sum;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.i_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready = (state == ST_IDLE);
  assign bus.o_busy  = (state != ST_IDLE);
  assign bus.o_valid = (state == ST_DONE);
  assign bus.o_prod  = {acc_hi, acc_lo};

endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul: one instance with EARLY_EXIT=0 (index 0) and one
// with EARLY_EXIT=1 (index 1), driven with identical directed operations.
module tb_shift_add_mul;

`ifdef SHIFT_ADD_MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_add_mul_if bus0 ();
  shift_add_mul_if bus1 ();

  shift_add_mul #(.EARLY_EXIT(0)) dut_fixed (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus0)
  );

  shift_add_mul #(.EARLY_EXIT(1)) dut_early (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1)
  );

  logic [1:0]  ov, ordy, obusy;
  logic [63:0] oprod [2];
  assign ov       = {bus1.o_valid, bus0.o_valid};
  assign ordy     = {bus1.o_ready, bus0.o_ready};
  assign obusy    = {bus1.o_busy,  bus0.o_busy};
  assign oprod[0] = bus0.o_prod;
  assign oprod[1] = bus1.o_prod;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          armed    [2];
  logic [63:0] exp_prod [2];

  // ---------------- model ----------------
  function automatic logic [63:0] model_prod(logic [31:0] a, logic [31:0] b, bit s);
    logic [63:0] ea, eb;
    if (SIGNED_EN && s) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end else begin
      ea = {32'b0, a};
      eb = {32'b0, b};
    end
    return ea * eb;
  endfunction

  // Edges from the accept edge (counted as 1) to the edge that raises o_valid.
  function automatic int model_lat(bit early, logic [31:0] a, logic [31:0] b, bit s);
    bit          sg;
    logic [31:0] mb;
    int          calc;
    sg   = SIGNED_EN && s;
    mb   = (sg && b[31]) ? (32'd0 - b) : b;
    calc = 32;
    if (early) begin
      calc = 1;
      for (int i = 0; i < 32; i++) if (mb[i]) calc = i + 1;
    end
    return 1 + calc + ((sg && (a[31] ^ b[31])) ? 2 : 0);
  endfunction

  // ---------------- checks ----------------
  task automatic check64(string name, int k, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h", name, k, got, want);
    end
  endtask

  task automatic checkbit(string name, int k, logic got, logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %b want %b", name, k, got, want);
    end
  endtask

  task automatic checkint(string name, int k, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d want %0d", name, k, got, want);
    end
  endtask

  // Per-cycle compare process.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        checkbit("busy_vs_ready", k, obusy[k], ~ordy[k]);
        if (ov[k]) begin
          if (!armed[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_valid dut%0d: got o_valid=1 want 0", k);
          end else begin
            check64("prod", k, oprod[k], exp_prod[k]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit v, logic [31:0] a, logic [31:0] b, bit s, bit ack);
    bus0.i_valid = v; bus0.i_op_a = a; bus0.i_op_b = b; bus0.i_signed = s; bus0.i_ack = ack;
    bus1.i_valid = v; bus1.i_op_a = a; bus1.i_op_b = b; bus1.i_signed = s; bus1.i_ack = ack;
  endtask

  // Called and returns at a falling edge.
  task automatic run_op(logic [31:0] a, logic [31:0] b, bit s, logic [63:0] lit,
                        int lit_lat0, int lit_lat1, bit ack_with_valid, string tag);
    int lat [2];
    int want_lat [2];
    bit seen [2];
    int edges;
    for (int k = 0; k < 2; k++) begin
      exp_prod[k] = model_prod(a, b, s);
      want_lat[k] = model_lat(k == 1, a, b, s);
      seen[k]     = 1'b0;
      lat[k]      = -1;
      checkbit({tag, "_ready_before"}, k, ordy[k], 1'b1);
    end
    check64({tag, "_model_lit"}, 0, exp_prod[0], lit);
    drive(1'b1, a, b, s, 1'b0);
    for (int k = 0; k < 2; k++) armed[k] = 1'b1;
    edges = 0;
    while (!(seen[0] && seen[1]) && edges < 100) begin
      @(negedge clk);
      edges++;
      for (int k = 0; k < 2; k++) begin
        if (!seen[k] && ov[k]) begin
          seen[k] = 1'b1;
          lat[k]  = edges;
        end
      end
      if (edges == 1) drive(1'b0, ~a, b ^ 32'h5, s, 1'b0);
      if (edges == 4 && want_lat[0] > 6 && want_lat[1] > 6)
        drive(1'b1, 32'h9, 32'h9, ~s, 1'b1);
      if (edges == 5) drive(1'b0, a, b, s, 1'b0);
    end
    drive(1'b0, a, b, s, 1'b0);
    for (int k = 0; k < 2; k++) begin
      if (!seen[k]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout dut%0d: got no o_valid want latency %0d", tag, k, want_lat[k]);
      end else begin
        checkint({tag, "_latency"}, k, lat[k], want_lat[k]);
        check64({tag, "_prod_lit"}, k, oprod[k], lit);
      end
    end
    if (lit_lat0 >= 0) checkint({tag, "_latency_lit"}, 0, lat[0], lit_lat0);
    if (lit_lat1 >= 0) checkint({tag, "_latency_lit"}, 1, lat[1], lit_lat1);
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) checkbit({tag, "_hold_valid"}, k, ov[k], 1'b1);
    end
    if (ack_with_valid) drive(1'b1, 32'h11, 32'h11, s, 1'b1);
    else                drive(1'b0, a, b, s, 1'b1);
    for (int k = 0; k < 2; k++) armed[k] = 1'b0;
    @(negedge clk);
    drive(1'b0, a, b, s, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checkbit({tag, "_idle_after_ack"}, k, ordy[k], 1'b1);
      checkbit({tag, "_valid_after_ack"}, k, ov[k], 1'b0);
    end
  endtask

  initial begin
    armed[0] = 1'b0;
    armed[1] = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkbit("reset_ready", k, ordy[k], 1'b1);
      checkbit("reset_valid", k, ov[k], 1'b0);
      checkbit("reset_busy",  k, obusy[k], 1'b0);
      check64 ("reset_prod",  k, oprod[k], 64'h0);
    end
    rst = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 64'd42, 33, 4, 1'b0, "7x6");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 33, 33, 1'b0, "max");
    run_op(32'h1234, 32'h0, 1'b0, 64'h0, 33, 2, 1'b0, "b0");
    run_op(32'hDEADBEEF, 32'h1, 1'b0, 64'h00000000DEADBEEF, 33, 2, 1'b0, "b1");
    run_op(32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 33, 18, 1'b0, "pow2");
    run_op(32'hFFFFFFFD, 32'd5, 1'b1,
           SIGNED_EN ? 64'hFFFFFFFFFFFFFFF1 : 64'h00000004FFFFFFF1, -1, -1, 1'b0, "m3x5");
    run_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, -1, -1, 1'b0, "minxmin");
    run_op(32'h80000000, 32'd3, 1'b1,
           SIGNED_EN ? 64'hFFFFFFFE80000000 : 64'h0000000180000000, -1, -1, 1'b0, "minx3");

    // Abort in the middle of CALC.
    drive(1'b1, 32'h00012345, 32'hFFFFFFFF, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    for (int k = 0; k < 2; k++) checkbit("busy_mid_calc", k, obusy[k], 1'b1);
    armed[0] = 1'b0;
    armed[1] = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkbit("abort_ready", k, ordy[k], 1'b1);
      checkbit("abort_valid", k, ov[k], 1'b0);
      checkbit("abort_busy",  k, obusy[k], 1'b0);
      check64 ("abort_prod",  k, oprod[k], 64'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd3, 32'd4, 1'b0, 64'd12, 33, 4, 1'b1, "after_reset");
    run_op(32'd100, 32'd1000, 1'b0, 64'd100000, 33, 11, 1'b0, "100x1000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 The block SHALL have parameter EARLY_EXIT, default 1; when 1, CALC ends as soon as the remaining multiplier bits are all zero.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_valid, input, 1 bit: the requester presents an operation.
REQ-005 The block SHALL have port o_ready, output, 1 bit: the block can accept an operation (state IDLE).
REQ-006 The block SHALL have ports i_op_a and i_op_b, input, 32 bits each: multiplicand and multiplier.
REQ-007 The block SHALL have port i_signed, input, 1 bit: treat operands as two's complement.
REQ-008 The block SHALL have port o_valid, output, 1 bit: o_prod holds a result.
REQ-009 The block SHALL have port i_ack, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port o_prod, output, 64 bits: the product.
REQ-011 The block SHALL have port o_busy, output, 1 bit: the block is in any state other than IDLE.

Function
REQ-012 The block SHALL implement the states IDLE, CALC, NEG_LO, NEG_HI and DONE.
REQ-013 Transfer on the input side SHALL occur on a rising edge with i_valid=1 and o_ready=1; operands are latched and the state goes IDLE->CALC.
REQ-014 Each CALC cycle SHALL, if multiplier bit0=1, add the multiplicand to acc_hi through the shared 32-bit adder (cin=0); otherwise it adds 0.
REQ-015 Each CALC cycle SHALL then shift {adder cout, sum, acc_lo} right by one bit and shift the multiplier right by one bit.
REQ-016 CALC SHALL run exactly 32 cycles when EARLY_EXIT=0.
REQ-017 When EARLY_EXIT=1, CALC SHALL run until the multiplier is zero; remaining shifts are applied in one step so the result is identical.
REQ-018 A zero multiplier at accept SHALL spend exactly 1 CALC cycle.
REQ-019 When CALC ends, the state SHALL go to NEG_LO if negation is pending, otherwise to DONE.
REQ-020 In DONE, o_valid SHALL be 1 and o_prod SHALL be stable until a rising edge with i_ack=1, which returns the state to IDLE.
REQ-021 The fixed latency SHALL be: o_valid rises 33 edges after accept for unsigned, EARLY_EXIT=0.
REQ-022 o_ready SHALL be 0 in DONE, so a new request is not accepted in the same cycle as i_ack; it is accepted from the following cycle.
REQ-023 i_ack outside DONE SHALL be ignored.
REQ-024 i_valid while busy SHALL be ignored, and no operand change is captured.
REQ-025 The adder SHALL be the only arithmetic resource; no "*" operator is used.

Reset
REQ-026 While i_reset=1, the state SHALL be IDLE, o_ready=1, o_valid=0, o_busy=0, o_prod=0, and all counters and accumulators SHALL be 0.
REQ-027 Assertion of i_reset SHALL abort an operation in any state immediately; the result is discarded and no o_valid pulse is produced.
REQ-028 The first accept after reset deassertion SHALL be possible on the first rising edge with i_reset=0.

Configuration
REQ-029 With the macro SHIFT_ADD_MUL_SIGNED_EN defined and i_signed=1, operands SHALL be converted to magnitudes at accept and the sign flag SHALL be set to (a[31] XOR b[31]).
REQ-030 With SHIFT_ADD_MUL_SIGNED_EN defined, a set sign flag SHALL negate the 64-bit product through the shared adder: NEG_LO computes ~lo+1 and stores the carry, and NEG_HI computes ~hi+carry; this adds 2 cycles.
REQ-031 With SHIFT_ADD_MUL_SIGNED_EN undefined, i_signed SHALL be ignored, the NEG states SHALL be unreachable or removed, and all products SHALL be unsigned.

Structure
REQ-032 A shared package SHALL hold the state enum type, the constant MUL_W=32 and the constant MUL_ITER=32.
REQ-033 The block SHALL instantiate exactly one sub-module, FA_32bit (the team's 32-bit ripple adder), with its operand, cin and cout muxed by state.

Verification
REQ-034 With EARLY_EXIT=0, a=7 and b=6 unsigned SHALL give o_prod=42, with o_valid exactly 33 edges after accept.
REQ-035 a=0xFFFFFFFF and b=0xFFFFFFFF unsigned SHALL give o_prod=0xFFFFFFFE00000001, exercising the carry into bit 63.
REQ-036 With the macro defined and signed, a=-3 and b=5 SHALL give 0xFFFFFFFFFFFFFFF1; a=0x80000000 and b=0x80000000 SHALL give 0x4000000000000000.
REQ-037 With EARLY_EXIT=1, b=0 SHALL give o_prod=0 with o_valid 2 edges after accept, and b=1 SHALL give o_prod=a after 2 CALC cycles or fewer.
REQ-038 Holding i_ack=0 for 10 cycles in DONE SHALL keep o_valid=1 and o_prod constant; i_valid pulsed during CALC SHALL produce no second result.
REQ-039 Asserting i_reset mid-CALC (cycle 15) SHALL give the reset values on all outputs at once; a next op of 3*4 SHALL return 12.
